// File: rtl/mem_host_ctrl.sv
// Host-side initiator for the 8x8 memory cell: turns write / read / 8-word
// wrapping burst requests into select/op pin cycles and returns read data.
module mem_host_ctrl #(
    parameter int READ_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic       req_burst,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [2:0] rsp_addr,
    output logic       rsp_last,
    output logic       mem_select,
    output logic       mem_op,
    output logic       mem_adr0,
    output logic       mem_adr1,
    output logic       mem_adr2,
    output logic       mem_i0,
    output logic       mem_i1,
    output logic       mem_i2,
    output logic       mem_i3,
    output logic       mem_i4,
    output logic       mem_i5,
    output logic       mem_i6,
    output logic       mem_i7,
    input  logic       mem_o0,
    input  logic       mem_o1,
    input  logic       mem_o2,
    input  logic       mem_o3,
    input  logic       mem_o4,
    input  logic       mem_o5,
    input  logic       mem_o6,
    input  logic       mem_o7
);

    typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_WAIT, RSP} state_t;

    localparam logic [2:0] LAT_LOAD = (READ_LAT > 0) ? 3'(READ_LAT - 1) : 3'd0;

    state_t     state;
    logic [2:0] addr_q;
    logic [2:0] adr_q;
    logic [7:0] din_q;
    logic       burst_q;
    logic [2:0] beat;
    logic [2:0] lat_cnt;
    logic [7:0] mem_rd;
    logic       cap;

    assign mem_rd = {mem_o0, mem_o1, mem_o2, mem_o3, mem_o4, mem_o5, mem_o6, mem_o7};
    assign {mem_adr0, mem_adr1, mem_adr2} = adr_q;
    assign {mem_i0, mem_i1, mem_i2, mem_i3, mem_i4, mem_i5, mem_i6, mem_i7} = din_q;

    // Last addressed cycle: RD_ADDR itself for a combinational cell, else end of RD_WAIT.
    assign cap = ((state == RD_ADDR) && (READ_LAT == 0)) ||
                 ((state == RD_WAIT) && (lat_cnt == 3'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            adr_q      <= '0;
            din_q      <= '0;
            burst_q    <= 1'b0;
            beat       <= '0;
            lat_cnt    <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_addr   <= '0;
            rsp_last   <= 1'b0;
            mem_select <= 1'b0;
            mem_op     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        addr_q     <= req_addr;
                        adr_q      <= req_addr;
                        mem_select <= 1'b1;
                        beat       <= '0;
                        if (req_wr) begin
                            mem_op  <= 1'b1;
                            din_q   <= req_wdata;
                            burst_q <= 1'b0;
                            state   <= WRITE;
                        end else begin
                            mem_op  <= 1'b0;
                            burst_q <= req_burst;
                            state   <= RD_ADDR;
                        end
                    end
                end
                WRITE: begin
                    mem_select <= 1'b0;
                    mem_op     <= 1'b0;
                    adr_q      <= '0;
                    din_q      <= '0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                RD_ADDR, RD_WAIT: begin
                    if (cap) begin
                        rsp_data   <= mem_rd;
                        rsp_addr   <= addr_q;
                        rsp_last   <= !burst_q || (beat == 3'd7);
                        rsp_valid  <= 1'b1;
                        mem_select <= 1'b0;
                        state      <= RSP;
                    end else if (state == RD_ADDR) begin
                        lat_cnt <= LAT_LOAD;
                        state   <= RD_WAIT;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (burst_q && (beat != 3'd7)) begin
                            beat       <= beat + 3'd1;
                            addr_q     <= addr_q + 3'd1;
                            adr_q      <= addr_q + 3'd1;
                            mem_select <= 1'b1;
                            state      <= RD_ADDR;
                        end else begin
                            adr_q     <= '0;
                            beat      <= '0;
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_host_ctrl.sv
// Bench: two controllers (READ_LAT=1 on index 1, READ_LAT=0 on index 0), each
// with its own behavioural 8x8 memory, driven from vector tables and sequences.
module tb_mem_host_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      req_valid, req_ready, req_wr, req_burst;
    logic [1:0][2:0] req_addr;
    logic [1:0][7:0] req_wdata;
    logic [1:0]      rsp_valid, rsp_ready, rsp_last;
    logic [1:0][7:0] rsp_data;
    logic [1:0][2:0] rsp_addr;
    logic [1:0]      mem_select, mem_op;
    logic [1:0][2:0] adr;
    logic [1:0][7:0] din;
    logic [7:0]      mo0, mo1;
    logic [7:0]      mem0 [8];
    logic [7:0]      mem1 [8];

    mem_host_ctrl #(.READ_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
        .req_burst(req_burst[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_addr(rsp_addr[1]), .rsp_last(rsp_last[1]),
        .mem_select(mem_select[1]), .mem_op(mem_op[1]),
        .mem_adr0(adr[1][2]), .mem_adr1(adr[1][1]), .mem_adr2(adr[1][0]),
        .mem_i0(din[1][7]), .mem_i1(din[1][6]), .mem_i2(din[1][5]), .mem_i3(din[1][4]),
        .mem_i4(din[1][3]), .mem_i5(din[1][2]), .mem_i6(din[1][1]), .mem_i7(din[1][0]),
        .mem_o0(mo1[7]), .mem_o1(mo1[6]), .mem_o2(mo1[5]), .mem_o3(mo1[4]),
        .mem_o4(mo1[3]), .mem_o5(mo1[2]), .mem_o6(mo1[1]), .mem_o7(mo1[0])
    );

    mem_host_ctrl #(.READ_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
        .req_burst(req_burst[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_addr(rsp_addr[0]), .rsp_last(rsp_last[0]),
        .mem_select(mem_select[0]), .mem_op(mem_op[0]),
        .mem_adr0(adr[0][2]), .mem_adr1(adr[0][1]), .mem_adr2(adr[0][0]),
        .mem_i0(din[0][7]), .mem_i1(din[0][6]), .mem_i2(din[0][5]), .mem_i3(din[0][4]),
        .mem_i4(din[0][3]), .mem_i5(din[0][2]), .mem_i6(din[0][1]), .mem_i7(din[0][0]),
        .mem_o0(mo0[7]), .mem_o1(mo0[6]), .mem_o2(mo0[5]), .mem_o3(mo0[4]),
        .mem_o4(mo0[3]), .mem_o5(mo0[2]), .mem_o6(mo0[1]), .mem_o7(mo0[0])
    );

    // Memory cell models: registered read for index 1, combinational for index 0.
    always @(posedge clk) begin
        if (mem_select[1] && mem_op[1])  mem1[adr[1]] <= din[1];
        if (mem_select[1] && !mem_op[1]) mo1 <= mem1[adr[1]];
        if (mem_select[0] && mem_op[0])  mem0[adr[0]] <= din[0];
    end
    always_comb mo0 = (mem_select[0] && !mem_op[0]) ? mem0[adr[0]] : 8'h00;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_at(input int d, input logic [2:0] a);
        return (d == 1) ? mem1[a] : mem0[a];
    endfunction

    task automatic do_write(input int d, input logic [2:0] a, input logic [7:0] v);
        @(negedge clk);
        chk("wr_ready", req_ready[d], 1'b1);
        req_valid[d] = 1'b1; req_wr[d] = 1'b1; req_burst[d] = 1'b0;
        req_addr[d] = a; req_wdata[d] = v;
        @(negedge clk);
        req_valid[d] = 1'b0;
        chk("wr_sel", mem_select[d], 1'b1);
        chk("wr_op", mem_op[d], 1'b1);
        chk("wr_adr", adr[d], a);
        chk("wr_din", din[d], v);
        chk("wr_busy", req_ready[d], 1'b0);
        @(negedge clk);
        chk("wr_sel_off", mem_select[d], 1'b0);
        chk("wr_ready_again", req_ready[d], 1'b1);
        chk("wr_commit", mem_at(d, a), v);
    endtask

    task automatic do_read(input int d, input logic [2:0] a, input logic [7:0] v);
        int cyc;
        @(negedge clk);
        req_valid[d] = 1'b1; req_wr[d] = 1'b0; req_burst[d] = 1'b0; req_addr[d] = a;
        @(negedge clk);
        req_valid[d] = 1'b0;
        cyc = 0;
        while (!rsp_valid[d] && cyc < 50) begin @(negedge clk); cyc++; end
        chk("rd_latency", cyc, d + 1);
        chk("rd_data", rsp_data[d], v);
        chk("rd_addr", rsp_addr[d], a);
        chk("rd_last", rsp_last[d], 1'b1);
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk("rd_vld_drop", rsp_valid[d], 1'b0);
        chk("rd_ready_again", req_ready[d], 1'b1);
    endtask

    task automatic do_burst(input int d, input logic [2:0] start, input int stall_w, input int stall_n);
        int cyc;
        logic [2:0] a;
        logic [7:0] v;
        @(negedge clk);
        req_valid[d] = 1'b1; req_wr[d] = 1'b0; req_burst[d] = 1'b1; req_addr[d] = start;
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        req_valid[d] = 1'b0;
        cyc = 0;
        for (int w = 0; w < 8; w++) begin
            a = start + 3'(w);
            v = mem_at(d, a);
            while (!rsp_valid[d] && cyc < 300) begin @(negedge clk); cyc++; end
            chk("bst_vld", rsp_valid[d], 1'b1);
            chk("bst_data", rsp_data[d], v);
            chk("bst_addr", rsp_addr[d], a);
            chk("bst_last", rsp_last[d], (w == 7) ? 1'b1 : 1'b0);
            chk("bst_sel_rsp", mem_select[d], 1'b0);
            if (w == stall_w) begin
                rsp_ready[d] = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk); cyc++;
                    chk("stall_vld", rsp_valid[d], 1'b1);
                    chk("stall_data", rsp_data[d], v);
                    chk("stall_addr", rsp_addr[d], a);
                    chk("stall_sel", mem_select[d], 1'b0);
                end
                rsp_ready[d] = 1'b1;
            end
            if (w == 7) chk("bst_cycles", cyc, 8 * (2 + d) - 1 + stall_n);
            @(negedge clk); cyc++;
        end
        rsp_ready[d] = 1'b0;
        chk("bst_done_vld", rsp_valid[d], 1'b0);
        chk("bst_done_ready", req_ready[d], 1'b1);
    endtask

    task automatic chk_all_zero(input int d);
        chk("rst_rsp_valid", rsp_valid[d], 1'b0);
        chk("rst_rsp_data", rsp_data[d], 8'h00);
        chk("rst_rsp_addr", rsp_addr[d], 3'd0);
        chk("rst_rsp_last", rsp_last[d], 1'b0);
        chk("rst_sel", mem_select[d], 1'b0);
        chk("rst_op", mem_op[d], 1'b0);
        chk("rst_adr", adr[d], 3'd0);
        chk("rst_din", din[d], 8'h00);
        chk("rst_req_ready", req_ready[d], 1'b0);
    endtask

    typedef struct {
        bit         wr;
        logic [2:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t vt[12];

    initial begin
        int seen;
        vt[0]  = '{1'b1, 3'd0, 8'h65};
        vt[1]  = '{1'b1, 3'd1, 8'h6E};
        vt[2]  = '{1'b1, 3'd2, 8'h67};
        vt[3]  = '{1'b1, 3'd3, 8'h69};
        vt[4]  = '{1'b1, 3'd4, 8'h6E};
        vt[5]  = '{1'b1, 3'd5, 8'h65};
        vt[6]  = '{1'b1, 3'd6, 8'h65};
        vt[7]  = '{1'b1, 3'd7, 8'h72};
        vt[8]  = '{1'b0, 3'd3, 8'h69};
        vt[9]  = '{1'b0, 3'd0, 8'h65};
        vt[10] = '{1'b0, 3'd7, 8'h72};
        vt[11] = '{1'b0, 3'd4, 8'h6E};

        req_valid = '0; req_wr = '0; req_burst = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = '0;

        repeat (2) @(negedge clk);
        chk_all_zero(1);
        chk_all_zero(0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst1", req_ready[1], 1'b1);
        chk("ready_after_rst0", req_ready[0], 1'b1);

        for (int d = 1; d >= 0; d--) begin
            for (int k = 0; k < 12; k++) begin
                if (vt[k].wr) do_write(d, vt[k].addr, vt[k].data);
                else          do_read(d, vt[k].addr, vt[k].data);
            end
        end

        // Pin ordering spot checks on the written image: addr 1 -> adr2 only, 0x65 pattern.
        do_write(1, 3'd1, 8'h6E);
        do_write(1, 3'd0, 8'h65);

        do_burst(1, 3'd5, -1, 0);
        do_burst(1, 3'd5, 2, 5);
        do_burst(0, 3'd5, -1, 0);

        // Reset in the middle of a burst.
        @(negedge clk);
        req_valid[1] = 1'b1; req_wr[1] = 1'b0; req_burst[1] = 1'b1; req_addr[1] = 3'd0;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_burst_rst", req_ready[1], 1'b1);
        seen = 0;
        repeat (30) begin @(negedge clk); if (rsp_valid[1]) seen++; end
        chk("no_rsp_after_rst", seen, 0);
        rsp_ready[1] = 1'b0;

        // Reset during a WRITE cycle: select must drop before the commit edge.
        @(negedge clk);
        req_valid[1] = 1'b1; req_wr[1] = 1'b1; req_addr[1] = 3'd2; req_wdata[1] = 8'hAA;
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("abort_wr_sel", mem_select[1], 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all_zero(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_wr_mem", mem1[2], 8'h67);
        do_read(1, 3'd2, 8'h67);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
